// File: rtl/mem_pkg.sv
// Shared types for the L1-to-lower-cache miss path: source IDs, arbiter states, depth default.
package mem_pkg;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } lc_src_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } lc_arb_state_t;

  localparam int LC_MAX_OUTSTANDING = 4;

  // Round-robin winner when both caches contend: whoever was not served last.
  function automatic lc_src_t rr_pick(input lc_src_t last);
    return (last == SRC_D) ? SRC_I : SRC_D;
  endfunction

endpackage

// File: rtl/src_id_fifo.sv
// In-order FIFO of read source IDs; push lands next cycle, head is combinational from storage.
// Push when full and pop when empty are ignored; simultaneous push+pop keeps the count.
module src_id_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = LC_MAX_OUTSTANDING
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  lc_src_t push_dat,
  input  logic    pop,
  output lc_src_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  lc_src_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l1_miss_arbiter.sv
// Merges L1I/L1D fills and writebacks onto one lower-cache port; request issues 1 cycle after grant.
// Fill returns 1 cycle after response accept; lc_ready_out stays low until the fill is taken.
module l1_miss_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W          = 64,
  parameter int LINE_W          = 512,
  parameter int MAX_OUTSTANDING = LC_MAX_OUTSTANDING
) (
  input  logic              clk_in,
  input  logic              rst_N_in,
  input  logic              cs_N_in,

  input  logic              l1i_valid_in,
  input  logic [ADDR_W-1:0] l1i_addr_in,
  input  logic [LINE_W-1:0] l1i_value_in,
  input  logic              l1i_we_in,
  output logic              l1i_ready_out,
  output logic              l1i_valid_out,
  output logic [ADDR_W-1:0] l1i_addr_out,
  output logic [LINE_W-1:0] l1i_value_out,
  input  logic              l1i_ready_in,

  input  logic              l1d_valid_in,
  input  logic [ADDR_W-1:0] l1d_addr_in,
  input  logic [LINE_W-1:0] l1d_value_in,
  input  logic              l1d_we_in,
  output logic              l1d_ready_out,
  output logic              l1d_valid_out,
  output logic [ADDR_W-1:0] l1d_addr_out,
  output logic [LINE_W-1:0] l1d_value_out,
  input  logic              l1d_ready_in,

  output logic              lc_valid_out,
  output logic [ADDR_W-1:0] lc_addr_out,
  output logic [LINE_W-1:0] lc_value_out,
  output logic              lc_we_out,
  input  logic              lc_ready_in,

  input  logic              lc_valid_in,
  input  logic [ADDR_W-1:0] lc_addr_in,
  input  logic [LINE_W-1:0] lc_value_in,
  output logic              lc_ready_out,

  output logic              err_out
);

  lc_arb_state_t     state;
  lc_src_t           last_grant;
  logic              elig_i;
  logic              elig_d;
  logic              grant_i;
  logic              grant_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  lc_src_t           fifo_head;

  logic              resp_hs;
  logic              fill_hs;
  logic              resp_valid;
  lc_src_t           resp_dst;
  logic [ADDR_W-1:0] resp_addr;
  logic [LINE_W-1:0] resp_value;

  // A full ID FIFO only holds back reads; writebacks never come back.
  assign elig_i = l1i_valid_in && (l1i_we_in || !fifo_full);
  assign elig_d = l1d_valid_in && (l1d_we_in || !fifo_full);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_N_in && !cs_N_in && (state == IDLE)) begin
      if (elig_i && elig_d) begin
        grant_i = (rr_pick(last_grant) == SRC_I);
        grant_d = (rr_pick(last_grant) == SRC_D);
      end else begin
        grant_i = elig_i;
        grant_d = elig_d;
      end
    end
  end

  assign l1i_ready_out = grant_i;
  assign l1d_ready_out = grant_d;
  assign fifo_push     = (grant_i && !l1i_we_in) || (grant_d && !l1d_we_in);

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state        <= IDLE;
      last_grant   <= SRC_I;
      lc_valid_out <= 1'b0;
      lc_addr_out  <= '0;
      lc_value_out <= '0;
      lc_we_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state        <= SEND;
            lc_valid_out <= 1'b1;
            last_grant   <= grant_d ? SRC_D : SRC_I;
            lc_addr_out  <= grant_d ? l1d_addr_in  : l1i_addr_in;
            lc_value_out <= grant_d ? l1d_value_in : l1i_value_in;
            lc_we_out    <= grant_d ? l1d_we_in    : l1i_we_in;
          end
        end
        SEND: begin
          if (lc_ready_in) begin
            state        <= IDLE;
            lc_valid_out <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          lc_valid_out <= 1'b0;
        end
      endcase
    end
  end

  src_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_src_id_fifo (
    .clk      (clk_in),
    .rst_n    (rst_N_in),
    .push     (fifo_push),
    .push_dat (grant_d ? SRC_D : SRC_I),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Single response slot: no new response until the current fill is taken.
  assign lc_ready_out = rst_N_in && !resp_valid;
  assign resp_hs      = lc_valid_in && lc_ready_out;
  assign fifo_pop     = resp_hs && !fifo_empty;
  assign fill_hs      = (l1i_valid_out && l1i_ready_in) || (l1d_valid_out && l1d_ready_in);

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      resp_valid <= 1'b0;
      resp_dst   <= SRC_I;
      resp_addr  <= '0;
      resp_value <= '0;
      err_out    <= 1'b0;
    end else if (fill_hs) begin
      resp_valid <= 1'b0;
    end else if (resp_hs) begin
      if (fifo_empty) begin
        err_out <= 1'b1;
      end else begin
        resp_valid <= 1'b1;
        resp_dst   <= fifo_head;
        resp_addr  <= lc_addr_in;
        resp_value <= lc_value_in;
      end
    end
  end

  assign l1i_valid_out = resp_valid && (resp_dst == SRC_I);
  assign l1d_valid_out = resp_valid && (resp_dst == SRC_D);
  assign l1i_addr_out  = l1i_valid_out ? resp_addr  : '0;
  assign l1i_value_out = l1i_valid_out ? resp_value : '0;
  assign l1d_addr_out  = l1d_valid_out ? resp_addr  : '0;
  assign l1d_value_out = l1d_valid_out ? resp_value : '0;

endmodule

// File: doc/l1_miss_arbiter.md
# l1_miss_arbiter

Arbitrates line-fill reads and writebacks from the L1 instruction cache and the L1 data cache onto the single lower-cache (`lc_*`) port. It sits directly downstream of both L1s and replaces their unconnected `lc_*` outputs in `ozone`. Responses return in order and are routed back to the cache that issued the read.

## Interface
- `ADDR_W`, 64, address width on every port.
- `LINE_W`, 512, cache line width.
- `MAX_OUTSTANDING`, 4, maximum number of reads in flight downstream (source-ID FIFO depth).
- `clk_in` input 1: the single clock.
- `rst_N_in` input 1: reset, asynchronous and active-low.
- `cs_N_in` input 1: chip select, active-low. While high, no new grants are made; responses still drain.
- `l1i_valid_in` / `l1d_valid_in` input 1: the cache presents a request.
- `l1i_addr_in` / `l1d_addr_in` input ADDR_W: line address of the request.
- `l1i_value_in` / `l1d_value_in` input LINE_W: writeback data, used only when `we` is set.
- `l1i_we_in` / `l1d_we_in` input 1: 1 = writeback, 0 = fill read.
- `l1i_ready_out` / `l1d_ready_out` output 1: the request is accepted this cycle.
- `l1i_valid_out` / `l1d_valid_out` output 1: a fill response is presented to the cache.
- `l1i_addr_out` / `l1d_addr_out` output ADDR_W: fill address.
- `l1i_value_out` / `l1d_value_out` output LINE_W: fill data.
- `l1i_ready_in` / `l1d_ready_in` input 1: the cache accepts the fill.
- `lc_valid_out`, `lc_addr_out` (ADDR_W), `lc_value_out` (LINE_W), `lc_we_out`, all outputs: downstream request.
- `lc_ready_in` input 1: downstream accepts the request.
- `lc_valid_in`, `lc_addr_in` (ADDR_W), `lc_value_in` (LINE_W), all inputs: downstream read response.
- `lc_ready_out` output 1: the arbiter can accept a response.
- `err_out` output 1: sticky flag, set when a response arrives with no read outstanding.

## Operation
- Handshakes: a transfer occurs when valid and ready are both high on a rising edge. Requesters hold valid and payload stable until they see ready.
- Request FSM has two states, IDLE and SEND.
- IDLE: grant when `cs_N_in` = 0 and at least one source is eligible.
  - A source is eligible if its valid is high and either it is a write or the ID FIFO is not full.
  - If both sources are eligible, round-robin decides using `last_grant`. The first grant after reset goes to L1D.
  - If only one source is eligible, it is granted regardless of `last_grant`.
- On a grant: assert that source's `ready_out` combinationally for one cycle, latch addr, value and we, update `last_grant`, push the source ID into the FIFO if the request is a read, then go to SEND.
- SEND: drive `lc_valid_out` = 1 with the latched fields. On `lc_ready_in`, return to IDLE. Writes are posted and produce no response.
- Response register: `lc_ready_out` = !resp_valid.
  - On a response handshake, capture addr and value, pop the FIFO head, and set resp_valid with the destination taken from the popped ID.
  - The response is presented on the destination's `valid_out` until that cache's `ready_in` is high, then resp_valid clears.
  - If a response arrives while the FIFO is empty: accept and discard it, set `err_out`, and leave the FIFO untouched.
- A FIFO push and pop in the same cycle are both performed; the count is unchanged.
- Reset values: every valid/ready output is 0, addr/value/we outputs are 0, `err_out` = 0, FIFO empty, FSM in IDLE, `last_grant` = L1I.
- Reset asserted mid-transaction discards all in-flight state. The downstream level is reset on the same `rst_N_in`.

## Timing
- Request accepted in cycle N → `lc_valid_out` is high from N+1.
- Request throughput is at most one every 2 cycles, because of the IDLE bubble after SEND.
- Response accepted in cycle N → `l1x_valid_out` is high from N+1.
- `lc_ready_out` stays low until the cycle after the fill handshake with the destination cache.
- Response throughput is at most one every 2 cycles.
- A full FIFO blocks reads only; writebacks still proceed.

## Structure
- In `mem_pkg`:
  - `lc_src_t` enum with values SRC_I and SRC_D.
  - `lc_arb_state_t` enum with values IDLE and SEND.
  - `LC_MAX_OUTSTANDING` constant, default 4.
- One sub-module, `src_id_fifo`: a synchronous FIFO of `lc_src_t`, parameterised by depth, with push/pop/full/empty, wrap-around pointers and a count.

## Test plan
- L1D read of 0x1000 alone → `l1d_ready_out` high for 1 cycle, `lc_valid_out` high next cycle with addr 0x1000 and `we` = 0. Response value 0xAB.. → appears on `l1d_value_out` only, one cycle after the `lc` handshake.
- L1I and L1D requests held valid continuously → grants alternate D, I, D, I. Responses returned in order are routed to the matching cache.
- 4 reads outstanding (FIFO full) plus a pending L1I read and an L1D writeback → the writeback is granted with `lc_we_out` = 1, the read stalls until a response pops the FIFO.
- Response with zero reads outstanding → `lc_ready_out` high, response dropped, `err_out` = 1 and stays 1 until reset.
- Destination `ready_in` held low for 5 cycles → `lc_ready_out` = 0 throughout; a second response waits; data is held stable.
- Assert `rst_N_in` low in SEND with 2 reads outstanding → all outputs 0 immediately (asynchronous); after release, IDLE with an empty FIFO.
